// File: rtl/hamming_pkg.sv
// hamming_pkg: shared state encoding, default codeword width and length normalisation.
package hamming_pkg;
  typedef enum logic {IDLE, SEND} state_e;
  localparam int CW_WIDTH = 16;
  function automatic int norm_len(input int len, input int width);
    return (len == 0 || len > width) ? width : len;
  endfunction
endpackage

// File: rtl/bit_select_mux.sv
// bit_select_mux: parametrised WIDTH:1 combinational bit select.
module bit_select_mux #(
  parameter int WIDTH = 16,
  parameter int SW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SW-1:0]    sel,
  output logic             sel_bit
);
  assign sel_bit = data[sel];
endmodule

// File: rtl/codeword_serializer.sv
// codeword_serializer: captures a codeword and shifts it out one bit per accepted beat.
module codeword_serializer
  import hamming_pkg::*;
#(
  parameter int WIDTH = CW_WIDTH,
  parameter bit LSB_FIRST = 1'b1,
  parameter int LW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LW-1:0]    load_len,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_last,
  output logic             busy
);
  localparam int IW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LW-1:0] rem_q, rem_d, eff_len;
  logic sel_bit;
  bit_select_mux #(.WIDTH(WIDTH)) u_mux (.data(data_q), .sel(idx_q), .sel_bit(sel_bit));
  assign busy = state_q == SEND;
  assign ser_valid = busy;
  assign ser_last = busy && rem_q == LW'(1);
  assign ser_bit = busy && sel_bit;
  // Only combinational input path: a load can be taken as the final bit is accepted.
  assign load_ready = !busy || (ser_last && ser_ready);
  assign eff_len = LW'(norm_len(int'(load_len), WIDTH));
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    idx_d = idx_q;
    rem_d = rem_q;
    if (load_valid && load_ready) begin
      state_d = SEND;
      data_d = load_data;
      rem_d = eff_len;
      idx_d = LSB_FIRST ? '0 : IW'(eff_len - LW'(1));
    end else if (busy && ser_ready) begin
      rem_d = rem_q - LW'(1);
      idx_d = ser_last ? idx_q : (LSB_FIRST ? idx_q + IW'(1) : idx_q - IW'(1));
      state_d = ser_last ? IDLE : SEND;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q <= '0;
      idx_q <= '0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      idx_q <= idx_d;
      rem_q <= rem_d;
    end
  end
endmodule

// File: tb/tb_codeword_serializer.sv
// tb_codeword_serializer: directed vector table plus backpressure, back-to-back and reset sequences.
module tb_codeword_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic [4:0] load_len = '0;
  logic ser_ready = 1'b1;
  logic l_lr, l_sv, l_sb, l_sl, l_busy;
  logic m_lr, m_sv, m_sb, m_sl, m_busy;
  bit msb = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  codeword_serializer #(.WIDTH(16), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(l_lr),
    .load_data(load_data), .load_len(load_len), .ser_valid(l_sv),
    .ser_ready(ser_ready), .ser_bit(l_sb), .ser_last(l_sl), .busy(l_busy));

  codeword_serializer #(.WIDTH(16), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(m_lr),
    .load_data(load_data), .load_len(load_len), .ser_valid(m_sv),
    .ser_ready(ser_ready), .ser_bit(m_sb), .ser_last(m_sl), .busy(m_busy));

  wire o_lr = msb ? m_lr : l_lr;
  wire o_sv = msb ? m_sv : l_sv;
  wire o_sb = msb ? m_sb : l_sb;
  wire o_sl = msb ? m_sl : l_sl;
  wire o_busy = msb ? m_busy : l_busy;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  len;
    bit          msb;
    int          n;
    logic [15:0] seq;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_row(input vec_t v);
    msb = v.msb;
    @(negedge clk);
    chk("idle_load_ready", o_lr, 1'b1);
    chk("idle_busy", o_busy, 1'b0);
    load_valid = 1'b1;
    load_data = v.data;
    load_len = v.len;
    @(negedge clk);
    load_valid = 1'b0;
    for (int k = 0; k < v.n; k++) begin
      chk("row_valid", o_sv, 1'b1);
      chk("row_bit", o_sb, v.seq[k]);
      chk("row_last", o_sl, k == v.n - 1);
      @(negedge clk);
    end
    chk("row_done_busy", o_busy, 1'b0);
    chk("row_done_valid", o_sv, 1'b0);
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 5'd0,  1'b0, 16, 16'hA5C3};
    vecs[1] = '{16'h004B, 5'd7,  1'b1, 7,  16'h0069};
    vecs[2] = '{16'h1234, 5'd31, 1'b0, 16, 16'h1234};
    vecs[3] = '{16'h0003, 5'd2,  1'b0, 2,  16'h0003};
    vecs[4] = '{16'h8001, 5'd16, 1'b1, 16, 16'h8001};
    vecs[5] = '{16'h00F0, 5'd5,  1'b0, 5,  16'h0010};
    vecs[6] = '{16'h00F0, 5'd5,  1'b1, 5,  16'h0001};
    #1;
    chk("rst_load_ready", l_lr, 1'b1);
    chk("rst_valid", l_sv, 1'b0);
    chk("rst_bit", l_sb, 1'b0);
    chk("rst_last", l_sl, 1'b0);
    chk("rst_busy", l_busy, 1'b0);
    chk("rst_msb_busy", m_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) run_row(vecs[i]);

    // backpressure: 3rd bit held for three cycles, 19 cycles in total
    msb = 1'b0;
    @(negedge clk);
    load_valid = 1'b1;
    load_data = 16'hA5C3;
    load_len = 5'd0;
    @(negedge clk);
    load_valid = 1'b0;
    for (int c = 0; c < 19; c++) begin
      int k;
      logic [15:0] d;
      d = 16'hA5C3;
      k = (c <= 5) ? ((c < 2) ? c : 2) : c - 3;
      chk("bp_valid", o_sv, 1'b1);
      chk("bp_bit", o_sb, d[k]);
      chk("bp_last", o_sl, c == 18);
      ser_ready = !(c >= 2 && c <= 4);
      @(negedge clk);
    end
    ser_ready = 1'b1;
    chk("bp_done_busy", o_busy, 1'b0);

    // back-to-back: second codeword offered early, taken only on the last beat
    @(negedge clk);
    load_valid = 1'b1;
    load_data = 16'h000F;
    load_len = 5'd4;
    @(negedge clk);
    load_data = 16'h0001;
    load_len = 5'd2;
    for (int c = 0; c < 6; c++) begin
      logic [5:0] exp_bits;
      exp_bits = 6'b011111;
      chk("b2b_valid", o_sv, 1'b1);
      chk("b2b_bit", o_sb, exp_bits[c]);
      chk("b2b_last", o_sl, c == 3 || c == 5);
      if (c < 4) chk("b2b_load_ready", o_lr, c == 3);
      @(negedge clk);
      if (c == 3) load_valid = 1'b0;
    end
    chk("b2b_done_busy", o_busy, 1'b0);

    // mid-stream asynchronous reset at bit 5
    @(negedge clk);
    load_valid = 1'b1;
    load_data = 16'hFFFF;
    load_len = 5'd31;
    @(negedge clk);
    load_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("mr_bit", o_sb, 1'b1);
      @(negedge clk);
    end
    chk("mr_busy_before", o_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", o_sv, 1'b0);
    chk("mr_busy", o_busy, 1'b0);
    chk("mr_last", o_sl, 1'b0);
    chk("mr_bit_clr", o_sb, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_load_ready", o_lr, 1'b1);
    run_row(vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
